uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 138 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise par_en/par_typ are ignored.
module uart_tx_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] prescale,
    input  logic       data_valid,
    input  logic [7:0] p_data,
    input  logic       par_en,
    input  logic       par_typ,
    output logic       tx_out,
    output logic       busy
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state;
    logic [4:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] data_q;
    logic [4:0] ps_q;
    logic       par_en_q;
    logic       par_typ_q;
    logic       bit_done;
    logic [2:0] next_bit;
    logic [4:0] ps_norm;

    assign bit_done = (edge_cnt == ps_q);
    assign next_bit = bit_cnt + 3'd1;
    // Unsupported oversampling ratios fall back to 8x.
    assign ps_norm  = (prescale == 5'd7 || prescale == 5'd15 || prescale == 5'd31) ? prescale : 5'd7;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_bit = (^data_q) ^ par_typ_q;
`else
    logic unused_par;
    assign unused_par = ^{par_en, par_typ, par_en_q, par_typ_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            edge_cnt  <= 5'd0;
            bit_cnt   <= 3'd0;
            data_q    <= 8'd0;
            ps_q      <= 5'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    edge_cnt <= 5'd0;
                    bit_cnt  <= 3'd0;
                    if (data_valid && !busy) begin
                        data_q    <= p_data;
                        ps_q      <= ps_norm;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        edge_cnt <= 5'd0;
                        bit_cnt  <= 3'd0;
                        tx_out   <= data_q[0];
                        state    <= DATA;
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        edge_cnt <= 5'd0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                tx_out <= par_bit;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
`else
                            tx_out <= 1'b1;
                            state  <= STOP;
`endif
                        end else begin
                            bit_cnt <= next_bit;
                            tx_out  <= data_q[next_bit];
                        end
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        edge_cnt <= 5'd0;
                        tx_out   <= 1'b1;
                        state    <= STOP;
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
`endif
                STOP: begin
                    // Last stop cycle hands back to IDLE; IDLE guarantees one idle-high cycle.
                    if (bit_done) begin
                        edge_cnt <= 5'd0;
                        tx_out   <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: per-cycle waveform reference built from frame rules.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] prescale = 5'd7;
    logic       data_valid = 1'b0;
    logic [7:0] p_data = 8'd0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int busy_cycles = 0;
    logic cur_busy = 1'b0;
    // Each entry is the expected {busy, tx_out} for one clock cycle.
    logic [1:0] exp_q[$];

    uart_tx_serializer dut (
        .clk(clk), .rst(rst), .prescale(prescale), .data_valid(data_valid),
        .p_data(p_data), .par_en(par_en), .par_typ(par_typ),
        .tx_out(tx_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [4:0] ps, input logic pe, input logic pt);
        int bt;
        logic bits[$];
        bt = (ps == 5'd7 || ps == 5'd15 || ps == 5'd31) ? int'(ps) + 1 : 8;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        if (pe) bits.push_back((^d) ^ pt);
`else
        if (pe ^ pt ^ pe ^ pt) bits.push_back(1'b0);
`endif
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < bt; c++) exp_q.push_back({1'b1, bits[b]});
    endtask

    task automatic tick();
        logic [1:0] e;
        if (!rst) exp_q.delete();
        else if (data_valid && !cur_busy) push_frame(p_data, prescale, par_en, par_typ);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b01;
        @(posedge clk);
        #1;
        check_eq("busy", {31'd0, busy}, {31'd0, e[1]});
        check_eq("tx_out", {31'd0, tx_out}, {31'd0, e[0]});
        cur_busy = e[1];
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && (cur_busy || exp_q.size() != 0); i++) tick();
        tick();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] d, input logic [4:0] ps, input logic pe, input logic pt);
        p_data = d; prescale = ps; par_en = pe; par_typ = pt; data_valid = 1'b1;
        busy_cycles = 0;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        int gap;
        for (int i = 0; i < 3; i++) tick();
        check_eq("reset_tx", {31'd0, tx_out}, 32'd1);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();

        send(8'hA5, 5'd7, 1'b0, 1'b0);
        wait_idle();
        check_eq("len_a5", busy_cycles, 80);

        send(8'h07, 5'd15, 1'b1, 1'b0);
        for (int i = 0; i < 16 * 9 + 1; i++) tick();
        check_eq("parity_07", {31'd0, tx_out}, 32'd1);
        wait_idle();
`ifdef UART_TX_PARITY_EN
        check_eq("len_07", busy_cycles, 176);
`else
        check_eq("len_07", busy_cycles, 160);
`endif

        send(8'h03, 5'd31, 1'b1, 1'b1);
        wait_idle();
`ifdef UART_TX_PARITY_EN
        check_eq("len_03", busy_cycles, 352);
`else
        check_eq("len_03", busy_cycles, 320);
`endif

        // Mid-frame request and input changes must not disturb the frame.
        send(8'h5A, 5'd7, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        p_data = 8'hFF; prescale = 5'd31; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        data_valid = 1'b0;
        wait_idle();
        check_eq("len_ignore", busy_cycles, 80);

        // Reset during data bit 3.
        send(8'hC3, 5'd7, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) tick();
        rst = 1'b0;
        tick();
        check_eq("abort_tx", {31'd0, tx_out}, 32'd1);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();
        send(8'h3C, 5'd7, 1'b0, 1'b0);
        wait_idle();
        check_eq("len_after_rst", busy_cycles, 80);

        // Illegal prescale and back-to-back requests.
        p_data = 8'h00; prescale = 5'd9; par_en = 1'b0; data_valid = 1'b1;
        busy_cycles = 0;
        tick();
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        check_eq("len_ps9", busy_cycles, 80);
        gap = 0;
        for (int i = 0; i < 20 && busy === 1'b0; i++) begin
            tick();
            gap++;
        end
        check_eq("idle_gap", gap, 1);
        data_valid = 1'b0;
        wait_idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 6000; i++) begin
            data_valid = ($urandom_range(0, 7) == 0);
            p_data = 8'($urandom);
            case ($urandom_range(0, 3))
                0: prescale = 5'd7;
                1: prescale = 5'd15;
                2: prescale = 5'd31;
                default: prescale = 5'($urandom);
            endcase
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
            rst = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst = 1'b1;
        data_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
